ps2_scancode_rx: RTL and testbench
==================================

Name: ps2_scancode_rx

Overview:
PS/2 keyboard frame receiver, directly upstream of the scan-code consumer in the keyboard-to-display/alarm path. It feeds that consumer's 8-bit `code` / 1-cycle `tick` inputs, and raises `correct` on frames that pass the checks.
- Synchronises and de-glitches `ps2c`, then deserialises 11-bit frames: start, 8 data bits LSB-first, odd parity, stop.
- Validates each frame and recovers from partial frames with an inactivity timeout.

Parameters:
- FILTER_LEN, 8: consecutive equal synchronised `ps2c` samples required before the filtered clock changes.
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered falling edge that abort a frame. The same count is the idle time required in WAIT_IDLE; 1 ms at 50 MHz.
- CNT_W, 16: width of the timeout/idle counter; must hold TIMEOUT_CYCLES.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset.
- EN, in, 1: receiver enable.
- ps2d, in, 1: PS/2 data line, asynchronous.
- ps2c, in, 1: PS/2 clock line, asynchronous.
- code, out, 8: last valid scan code.
- tick, out, 1: one-cycle pulse when `code` is updated.
- correct, out, 1: status of the last completed or aborted frame (1 = good).

Behaviour:
- Clocking and reset: one clock `clk`. `rst` is asynchronous, active-low.
- Reset values: `code`=8'h00, `tick`=0, `correct`=0, FSM=WAIT_IDLE, filtered clock=1, break_pending=0, all counters 0.
- Input conditioning:
  - `ps2c` and `ps2d` each pass a 2-FF synchroniser.
  - The filtered clock takes the synchronised `ps2c` value only after FILTER_LEN consecutive identical samples.
  - A falling edge (fe) is the cycle the filtered clock goes 1→0. The synchronised `ps2d` is sampled in the fe cycle.
- FSM:
  - WAIT_IDLE: counter increments while the filtered clock is 1 and clears when it is 0. At TIMEOUT_CYCLES → IDLE. Entered after reset and on every EN 0→1.
  - IDLE: fe with data=0 → SHIFT, bitcnt=0. fe with data=1 (bad start) → stay in IDLE, `correct`<=0.
  - SHIFT: each fe shifts data into bit[bitcnt], LSB first, and increments bitcnt. On the 8th fe → PARITY.
  - PARITY: fe captures the parity bit → STOP.
  - STOP: fe evaluates the frame → IDLE.
    - Valid = (XOR of data and parity == 1) and stop==1.
    - Valid: `correct`<=1, and `code`/`tick` update per the feature rule.
    - Invalid: `correct`<=0, `code` held, no tick.
  - Timeout: in SHIFT, PARITY or STOP, the counter counts cycles since the last fe. Reaching TIMEOUT_CYCLES → IDLE, partial frame discarded, `correct`<=0.
- Latency: `tick` is asserted in the cycle after the STOP-state fe and lasts exactly 1 cycle. `code` is valid from that same cycle and is held until the next update.
- EN:
  - EN=0 forces WAIT_IDLE and clears bitcnt. Any in-progress frame is dropped.
  - `tick` is not asserted while EN=0; `code` and `correct` hold.
- Back-to-back frames: a start-bit fe arriving in the cycle `tick` is high is accepted normally.
- Reset mid-frame: immediate return to reset values; any pending tick is lost.

Optional Feature:
- Macro: PS2_BREAK_FILTER_EN.
- Defined (key-press codes only):
  - A valid 8'hF0 sets break_pending, produces no tick, and leaves `code` unchanged.
  - The next valid byte clears break_pending and produces no tick.
  - A valid 8'hE0 produces no tick and does not affect break_pending.
  - An invalid frame or a timeout clears break_pending.
  - `correct` still reflects every frame.
- Undefined: every valid byte, including F0 and E0, updates `code` and ticks. No break_pending logic.

Decomposition:
- Package ps2_pkg:
  - FSM state encoding: WAIT_IDLE, IDLE, SHIFT, PARITY, STOP.
  - BREAK_CODE=8'hF0, EXT_CODE=8'hE0, DATA_BITS=8, FRAME_BITS=11.
- Sub-module ps2_clk_filter: 2-FF synchronisers for both lines, FILTER_LEN debouncer, fe pulse output and synchronised data output.
- Top level: FSM, shift register, timeout counter, output registers.

Test Plan (PS/2 bit period 80 µs at 50 MHz unless stated):
1. Reset release, EN=1, lines idle 1.2 ms, then frame 0x1C with parity 0 and stop 1 → one `tick` of 1 cycle, `code`=8'h1C, `correct`=1.
2. Frame 0x1C with parity forced to 1 → no tick, `code` unchanged, `correct`=0. Next good frame 0x32 → `tick`, `code`=8'h32, `correct`=1.
3. 20 ns glitches on `ps2c` during the idle and data phases, frame 0x45 → `code`=8'h45 received intact, exactly one tick.
4. Frame stopped after 5 data bits, 2 ms silence, then frame 0x1C → `correct`=0 after the timeout, then `code`=8'h1C, `tick`, `correct`=1.
5. EN dropped mid-frame, raised mid-frame and held through a full frame 0x1C → no tick until 1 ms of idle has passed; the following frame is received correctly.
6. Sequence 0x1C, 0xF0, 0x1C:
   - PS2_BREAK_FILTER_EN defined → exactly one tick (`code`=8'h1C).
   - Undefined → three ticks with `code` 8'h1C, 8'hF0, 8'h1C.

Source files
------------

// File: rtl/ps2_pkg.sv
// ============================================================================
// Module  : ps2_pkg
// Purpose : Shared state encoding, scan-code constants and frame check helper
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

  localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_SHIFT     = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam int         DATA_BITS  = 8;
  localparam int         FRAME_BITS = 11;

  // Odd parity over data+parity, and the stop bit must be 1.
  function automatic logic frame_ok(input logic [DATA_BITS-1:0] d,
                                    input logic p, input logic s);
    return (^{d, p}) & s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_clk_filter.sv
// ============================================================================
// Module  : ps2_clk_filter
// Purpose : 2-FF synchronisers for ps2c/ps2d, ps2c debouncer, falling-edge pulse
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2c,
  input  logic i_ps2d,
  output logic o_clk_filt,
  output logic o_fe,
  output logic o_data
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  logic          r_c_meta, r_c_sync;
  logic          r_d_meta, r_d_sync;
  logic          r_filt;
  logic          r_fe;
  logic [FW-1:0] r_cnt;

  // Counts consecutive synchronised samples that disagree with the filtered level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c_meta <= 1'b1;
      r_c_sync <= 1'b1;
      r_d_meta <= 1'b1;
      r_d_sync <= 1'b1;
      r_filt   <= 1'b1;
      r_fe     <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_c_meta <= i_ps2c;
      r_c_sync <= r_c_meta;
      r_d_meta <= i_ps2d;
      r_d_sync <= r_d_meta;
      r_fe     <= 1'b0;
      if (r_c_sync == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt <= r_c_sync;
        r_fe   <= r_filt;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_clk_filt = r_filt;
  assign o_fe       = r_fe;
  assign o_data     = r_d_sync;

endmodule

`default_nettype wire

// File: rtl/ps2_scancode_rx.sv
// ============================================================================
// Module  : ps2_scancode_rx
// Purpose : PS/2 keyboard frame receiver with validation and inactivity timeout.
//           Optional macro PS2_BREAK_FILTER_EN suppresses break/extended codes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic       ps2d,
  input  logic       ps2c,
  output logic [7:0] code,
  output logic       tick,
  output logic       correct
);

  logic                 w_clk_filt, w_fe, w_data;
  logic                 w_cnt_hit, w_timeout;
  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [2:0]           r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic [7:0]           r_code;
  logic                 r_tick;
  logic                 r_correct;
  logic                 r_en_d;
`ifdef PS2_BREAK_FILTER_EN
  logic                 r_bp;
`endif

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk       (clk),
    .rst       (rst),
    .i_ps2c    (ps2c),
    .i_ps2d    (ps2d),
    .o_clk_filt(w_clk_filt),
    .o_fe      (w_fe),
    .o_data    (w_data)
  );

  assign w_cnt_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_timeout = ((r_state == ST_SHIFT) || (r_state == ST_PARITY) ||
                      (r_state == ST_STOP)) && !w_fe && w_cnt_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_WAIT_IDLE;
      r_cnt     <= '0;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_code    <= 8'h00;
      r_tick    <= 1'b0;
      r_correct <= 1'b0;
      r_en_d    <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      r_bp      <= 1'b0;
`endif
    end else begin
      r_tick <= 1'b0;
      r_en_d <= EN;
      // Disabled, or just re-enabled: wait for a full idle period before framing.
      if (!EN || !r_en_d) begin
        r_state  <= ST_WAIT_IDLE;
        r_cnt    <= '0;
        r_bitcnt <= '0;
      end else if (w_timeout) begin
        r_state   <= ST_IDLE;
        r_cnt     <= '0;
        r_correct <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
        r_bp      <= 1'b0;
`endif
      end else begin
        case (r_state)
          ST_WAIT_IDLE: begin
            if (!w_clk_filt) begin
              r_cnt <= '0;
            end else if (w_cnt_hit) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_IDLE: begin
            r_cnt <= '0;
            if (w_fe) begin
              if (!w_data) begin
                r_state  <= ST_SHIFT;
                r_bitcnt <= '0;
              end else begin
                r_correct <= 1'b0;
              end
            end
          end
          ST_SHIFT: begin
            if (w_fe) begin
              r_shift[r_bitcnt] <= w_data;
              r_bitcnt          <= r_bitcnt + 1'b1;
              r_cnt             <= '0;
              if (r_bitcnt == 3'd7) r_state <= ST_PARITY;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_PARITY: begin
            if (w_fe) begin
              r_par   <= w_data;
              r_cnt   <= '0;
              r_state <= ST_STOP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (w_fe) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
              if (frame_ok(r_shift, r_par, w_data)) begin
                r_correct <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                if (r_shift == BREAK_CODE) begin
                  r_bp <= 1'b1;
                end else if (r_shift == EXT_CODE) begin
                  r_bp <= r_bp;
                end else if (r_bp) begin
                  r_bp <= 1'b0;
                end else begin
                  r_code <= r_shift;
                  r_tick <= 1'b1;
                end
`else
                r_code <= r_shift;
                r_tick <= 1'b1;
`endif
              end else begin
                r_correct <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
                r_bp      <= 1'b0;
`endif
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= ST_WAIT_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign code    = r_code;
  assign tick    = r_tick;
  assign correct = r_correct;

endmodule

`default_nettype wire

// File: tb/tb_ps2_scancode_rx.sv
// ============================================================================
// Module  : tb_ps2_scancode_rx
// Purpose : Self-checking bench for ps2_scancode_rx (table vectors + scoreboard)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_scancode_rx;

  localparam int TO = 300;
  localparam int H  = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       EN = 1'b0;
  logic       ps2d = 1'b1;
  logic       ps2c = 1'b1;
  logic [7:0] code;
  logic       tick;
  logic       correct;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_code = 8'h00;
  logic       m_correct = 1'b0;
  bit         m_bp = 1'b0;
  logic       prev_tick = 1'b0;

  typedef struct {
    logic [7:0] data;
    bit         flip_par;
    bit         stop;
    bit         exp_good;
  } vec_t;

  vec_t vecs[10];

  ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .EN     (EN),
    .ps2d   (ps2d),
    .ps2c   (ps2c),
    .code   (code),
    .tick   (tick),
    .correct(correct)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && tick) begin
      check("tick_width", {31'd0, prev_tick}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tick actual code=%0h required=no tick at %0t", code, $time);
      end else begin
        check("tick_code", {24'd0, code}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_tick = tick;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      m_correct = 1'b0;
      m_bp      = 1'b0;
    end else begin
      m_correct = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
      if (b == 8'hF0) m_bp = 1'b1;
      else if (b == 8'hE0) m_bp = m_bp;
      else if (m_bp) m_bp = 1'b0;
      else begin
        m_code = b;
        exp_q.push_back(b);
      end
`else
      m_code = b;
      exp_q.push_back(b);
`endif
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip, input bit stp,
                            input int nbits, input bit glitch);
    logic        par;
    logic [10:0] f;
    int          g;
    par = (~^b) ^ flip;
    f   = {stp, par, b, 1'b0};
    g   = glitch ? 2 : 0;
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      wait_cyc(H / 2);
      if (glitch) begin
        ps2c = 1'b0; wait_cyc(2); ps2c = 1'b1;
      end
      wait_cyc(H / 2 - g);
      ps2c = 1'b0;
      wait_cyc(H / 2);
      if (glitch) begin
        ps2c = 1'b1; wait_cyc(2); ps2c = 1'b0;
      end
      wait_cyc(H / 2 - g);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    wait_cyc(H);
  endtask

  task automatic good_frame(input logic [7:0] b);
    model_frame(b, 1'b1);
    send_frame(b, 1'b0, 1'b1, 11, 1'b0);
    wait_cyc(5);
    check("correct", {31'd0, correct}, {31'd0, m_correct});
    check("code", {24'd0, code}, {24'd0, m_code});
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h32, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{8'hF0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{8'h1C, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{8'hE0, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{8'h75, 1'b0, 1'b1, 1'b1};

    wait_cyc(3);
    check("rst_code", {24'd0, code}, 32'd0);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_correct", {31'd0, correct}, 32'd0);

    rst = 1'b1;
    EN  = 1'b1;
    wait_cyc(TO + 100);

    for (int i = 0; i < 10; i++) begin
      model_frame(vecs[i].data, vecs[i].exp_good);
      send_frame(vecs[i].data, vecs[i].flip_par, vecs[i].stop, 11, 1'b0);
      wait_cyc(5);
      check("vec_correct", {31'd0, correct}, {31'd0, m_correct});
      check("vec_code", {24'd0, code}, {24'd0, m_code});
    end

    // Glitches on ps2c in idle and throughout a frame.
    for (int i = 0; i < 3; i++) begin
      ps2c = 1'b0; wait_cyc(2); ps2c = 1'b1; wait_cyc(10);
    end
    model_frame(8'h45, 1'b1);
    send_frame(8'h45, 1'b0, 1'b1, 11, 1'b1);
    wait_cyc(5);
    check("glitch_code", {24'd0, code}, {24'd0, m_code});
    check("glitch_correct", {31'd0, correct}, 32'd1);

    // Partial frame then silence: timeout must discard it.
    send_frame(8'h6B, 1'b0, 1'b1, 6, 1'b0);
    wait_cyc(2 * TO);
    m_correct = 1'b0;
    m_bp      = 1'b0;
    check("timeout_correct", {31'd0, correct}, 32'd0);
    check("timeout_code", {24'd0, code}, {24'd0, m_code});
    good_frame(8'h1C);

    // EN dropped and raised mid-frame; traffic without an idle gap is ignored.
    send_frame(8'h5A, 1'b0, 1'b1, 3, 1'b0);
    EN = 1'b0;
    wait_cyc(5);
    check("en_off_correct", {31'd0, correct}, {31'd0, m_correct});
    check("en_off_code", {24'd0, code}, {24'd0, m_code});
    wait_cyc(H);
    EN = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b1, 6, 1'b0);
    send_frame(8'h3A, 1'b0, 1'b1, 11, 1'b0);
    wait_cyc(5);
    check("en_ignored_code", {24'd0, code}, {24'd0, m_code});
    wait_cyc(TO + 100);
    good_frame(8'h4D);

    // Make/break/make sequence.
    good_frame(8'h1C);
    good_frame(8'hF0);
    good_frame(8'h1C);

    // Asynchronous reset in the middle of a frame.
    send_frame(8'h29, 1'b0, 1'b1, 5, 1'b0);
    ps2c = 1'b0;
    wait_cyc(H / 2);
    rst = 1'b0;
    #1;
    check("midrst_code", {24'd0, code}, 32'd0);
    check("midrst_tick", {31'd0, tick}, 32'd0);
    check("midrst_correct", {31'd0, correct}, 32'd0);
    ps2c = 1'b1;
    ps2d = 1'b1;
    m_code    = 8'h00;
    m_correct = 1'b0;
    m_bp      = 1'b0;
    wait_cyc(5);
    rst = 1'b1;
    wait_cyc(TO + 100);
    good_frame(8'h29);

    wait_cyc(20);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
